// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants for the I2S/TDM transmitter.
//   - serial format encodings (value of fmt_lj)
//   - parameter defaults for i2s_tdm_tx
//   - engine state encoding
//   - clog2 helper used for port and counter widths
package i2s_pkg;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_SLOT_W     = 32;
    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_MCLK_DIV   = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: frame FIFO for the I2S/TDM transmitter.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_push, i_wdata      write request and frame (ignored when not ready)
//   i_pop                read request (ignored when empty)
//   o_rdata              head frame (valid when not empty)
//   o_ready              registered: next level < DEPTH
//   o_empty              level == 0
//   o_level              frames held
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_rdata,
    output logic                        o_ready,
    output logic                        o_empty,
    output logic [clog2(DEPTH+1)-1:0]   o_level
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_nxt;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && (r_level != '0);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage carries no reset; only pointers and level define contents.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt < LW'(DEPTH));
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_ready = r_ready;
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / left-justified / TDM serial transmitter with frame FIFO.
// Ports:
//   mclk, reset_n        sole clock, async active-low reset
//   enable               run the serial engine
//   fmt_lj               0 = Philips I2S (data one bclk after lrclk), 1 = left-justified
//   s_data, s_valid      frame input, channel 0 in the LSBs
//   s_ready, fifo_level  FIFO can accept / frames held
//   i2s_mclk             mclk pass-through
//   i2s_bclk, i2s_lrclk  bit clock / frame sync
//   i2s_data             serial data, changes with bclk falling
//   underrun             one-cycle pulse when a frame starts with the FIFO empty
// Build option: I2S_TX_UNDERRUN_HOLD_EN -- on underrun retransmit the previous
// frame instead of sending zeros.
//
// state   | meaning
// ST_IDLE | engine stopped, serial outputs low; next enabled cycle is bit 0
// ST_RUN  | bclk running, p advancing on every bclk fall
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int MCLK_DIV   = DEF_MCLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              mclk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              fmt_lj,
    input  logic [SAMPLE_W*CHANNELS-1:0]      s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                              i2s_mclk,
    output logic                              i2s_bclk,
    output logic                              i2s_lrclk,
    output logic                              i2s_data,
    output logic                              underrun
);
    localparam int FRAME_W    = SAMPLE_W*CHANNELS;
    localparam int FRAME_BITS = SLOT_W*CHANNELS;
    localparam int PW         = clog2(FRAME_BITS);
    localparam int DW         = clog2(MCLK_DIV);
    localparam int IW         = clog2(FRAME_W);

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [DW-1:0]    r_div;
    logic [PW-1:0]    r_p;
    logic             r_bclk;
    logic             r_lrclk;
    logic             r_data;
    logic             r_underrun;
    logic             r_fmt;
    logic [FRAME_W-1:0] r_hold;

    logic [FRAME_W-1:0] w_fifo_head;
    logic             w_fifo_empty;
    logic             w_fall_evt;
    logic             w_rise_evt;
    logic             w_frame_start;
    logic             w_pop;
    logic             w_fmt;
    logic [FRAME_W-1:0] w_next_hold;
    logic [FRAME_W-1:0] w_src;
    logic [IW-1:0]    w_idx;
    logic             w_bit;
    logic             w_lr;
    int               w_q;
    int               w_slot;
    int               w_k;

    i2s_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (mclk),
        .i_rst_n (reset_n),
        .i_push  (s_valid),
        .i_wdata (s_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_ready (s_ready),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = enable ? ST_RUN : ST_IDLE;
    end

    // The first enabled cycle counts as a bclk fall so bit 0 starts at once.
    always_comb begin
        w_fall_evt = enable && ((r_state == ST_IDLE) || (r_bclk && (r_div == '0)));
        w_rise_evt = enable && (r_state == ST_RUN) && !r_bclk && (r_div == '0);
    end

    always_comb begin
        w_frame_start = w_fall_evt && (r_p == '0);
        w_fmt         = w_frame_start ? fmt_lj : r_fmt;
        w_pop         = w_frame_start && !w_fifo_empty;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        w_next_hold   = w_fifo_empty ? r_hold : w_fifo_head;
`else
        w_next_hold   = w_fifo_empty ? '0 : w_fifo_head;
`endif
        // LJ bit 0 comes from the frame being loaded this cycle; I2S bit 0 is
        // still the last bit of the frame already in the holding register.
        if (w_fmt == FMT_LJ) begin
            w_q   = int'(r_p);
            w_src = w_frame_start ? w_next_hold : r_hold;
        end else begin
            w_q   = (r_p == '0) ? FRAME_BITS-1 : int'(r_p) - 1;
            w_src = r_hold;
        end
        w_slot = w_q / SLOT_W;
        w_k    = w_q % SLOT_W;
        w_idx  = IW'(w_slot*SAMPLE_W + SAMPLE_W - 1 - w_k);
        w_bit  = (w_k < SAMPLE_W) ? w_src[w_idx] : 1'b0;
        w_lr   = (int'(r_p) >= FRAME_BITS/2);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_div      <= '0;
            r_p        <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_data     <= 1'b0;
            r_underrun <= 1'b0;
            r_fmt      <= FMT_I2S;
            r_hold     <= '0;
        end else if (!enable) begin
            r_div      <= '0;
            r_p        <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_data     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_fall_evt) begin
                r_bclk  <= 1'b0;
                r_div   <= DW'(MCLK_DIV-1);
                r_lrclk <= w_lr;
                r_data  <= w_bit;
                r_p     <= (int'(r_p) == FRAME_BITS-1) ? '0 : r_p + PW'(1);
                if (w_frame_start) begin
                    r_hold     <= w_next_hold;
                    r_fmt      <= fmt_lj;
                    r_underrun <= w_fifo_empty;
                end
            end else if (w_rise_evt) begin
                r_bclk <= 1'b1;
                r_div  <= DW'(MCLK_DIV-1);
            end else begin
                r_div <= r_div - DW'(1);
            end
        end
    end

    assign i2s_mclk  = mclk;
    assign i2s_bclk  = r_bclk;
    assign i2s_lrclk = r_lrclk;
    assign i2s_data  = r_data;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
module tb_i2s_tdm_tx;

    typedef struct packed {
        logic lr;
        logic d;
    } exp_t;

    logic        mclk;
    logic        rst_n;
    // default instance: 16-bit samples, 32-bit slots, 2 channels
    logic        enable, fmt_lj, s_valid, s_ready;
    logic [31:0] s_data;
    logic [2:0]  fifo_level;
    logic        i2s_mclk, i2s_bclk, i2s_lrclk, i2s_data, underrun;
    // TDM instance: 16-bit slots, 4 channels
    logic        enable4, fmt4, s_valid4, s_ready4;
    logic [63:0] s_data4;
    logic [2:0]  level4;
    logic        i2s_mclk4, i2s_bclk4, i2s_lrclk4, i2s_data4, underrun4;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];
    logic [63:0] prev0 = '0;
    logic [63:0] prev4 = '0;

    i2s_tdm_tx dut (
        .mclk(mclk), .reset_n(rst_n), .enable(enable), .fmt_lj(fmt_lj),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .fifo_level(fifo_level),
        .i2s_mclk(i2s_mclk), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_data(i2s_data), .underrun(underrun)
    );

    i2s_tdm_tx #(.SLOT_W(16), .CHANNELS(4)) dut4 (
        .mclk(mclk), .reset_n(rst_n), .enable(enable4), .fmt_lj(fmt4),
        .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4), .fifo_level(level4),
        .i2s_mclk(i2s_mclk4), .i2s_bclk(i2s_bclk4), .i2s_lrclk(i2s_lrclk4),
        .i2s_data(i2s_data4), .underrun(underrun4)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Serial bit at frame position p, derived from the format definitions.
    function automatic logic model_bit(input logic [63:0] fr, input logic [63:0] prev,
                                       input int p, input bit lj, input int slot_w, input int ch);
        int fb, q, slot, k;
        logic [63:0] src, sh;
        fb = slot_w*ch;
        if (lj) begin
            q = p; src = fr;
        end else if (p == 0) begin
            q = fb-1; src = prev;
        end else begin
            q = p-1; src = fr;
        end
        slot = q / slot_w;
        k    = q % slot_w;
        if (k >= 16) return 1'b0;
        sh = src >> (slot*16 + 15 - k);
        return sh[0];
    endfunction

    task automatic enqueue_frame(input int sel, input logic [63:0] fr, input logic [63:0] prev, input bit lj);
        int slot_w, ch, fb;
        exp_t e;
        slot_w = (sel != 0) ? 16 : 32;
        ch     = (sel != 0) ? 4 : 2;
        fb     = slot_w*ch;
        for (int p = 0; p < fb; p++) begin
            e.lr = (p >= fb/2);
            e.d  = model_bit(fr, prev, p, lj, slot_w, ch);
            if (sel != 0) exp4_q.push_back(e);
            else          exp_q.push_back(e);
        end
    endtask

    task automatic push_frame(input int sel, input logic [63:0] fr, input bit enq, input bit lj);
        int w;
        w = 0;
        while ((((sel != 0) ? s_ready4 : s_ready) !== 1'b1) && w < 2000) begin
            @(negedge mclk);
            w++;
        end
        checks++;
        if (w >= 2000) begin
            errors++;
            $display("FAIL push_wait: s_ready got 0 expected 1");
            return;
        end
        if (sel != 0) begin s_data4 = fr; s_valid4 = 1'b1; end
        else begin s_data = fr[31:0]; s_valid = 1'b1; end
        @(negedge mclk);
        s_valid  = 1'b0;
        s_valid4 = 1'b0;
        if (enq) begin
            if (sel != 0) begin enqueue_frame(sel, fr, prev4, lj); prev4 = fr; end
            else begin enqueue_frame(sel, fr, prev0, lj); prev0 = fr; end
        end
    endtask

    // Compares lrclk/data at each bclk rise against the scoreboard; counts underrun pulses.
    task automatic check_bits(input int sel, input int n, input string name, output int n_under);
        int got, cyc;
        logic pb, cb, lr, d;
        exp_t e;
        got = 0; cyc = 0; n_under = 0;
        pb = (sel != 0) ? i2s_bclk4 : i2s_bclk;
        while (got < n && cyc < n*8 + 64) begin
            @(negedge mclk);
            cyc++;
            if (((sel != 0) ? underrun4 : underrun) === 1'b1) n_under++;
            cb = (sel != 0) ? i2s_bclk4 : i2s_bclk;
            lr = (sel != 0) ? i2s_lrclk4 : i2s_lrclk;
            d  = (sel != 0) ? i2s_data4 : i2s_data;
            if (cb === 1'b1 && pb === 1'b0) begin
                checks++;
                if (((sel != 0) ? exp4_q.size() : exp_q.size()) == 0) begin
                    errors++;
                    $display("FAIL %s bclk %0d: got lr/data %b%b expected none queued", name, got, lr, d);
                end else begin
                    e = (sel != 0) ? exp4_q.pop_front() : exp_q.pop_front();
                    if ({lr, d} !== {e.lr, e.d}) begin
                        errors++;
                        $display("FAIL %s bclk %0d: lr/data got %b%b expected %b%b", name, got, lr, d, e.lr, e.d);
                    end
                end
                got++;
            end
            pb = cb;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_timeout: bclk rises got %0d expected %0d", name, got, n);
        end
    endtask

    task automatic stop_and_check(input int sel, input string name);
        logic [2:0] o;
        if (sel != 0) enable4 = 1'b0; else enable = 1'b0;
        @(negedge mclk);
        o = (sel != 0) ? {i2s_bclk4, i2s_lrclk4, i2s_data4} : {i2s_bclk, i2s_lrclk, i2s_data};
        checks++;
        if (o !== 3'b000) begin
            errors++;
            $display("FAIL %s_disabled: bclk/lr/data got %b expected 000", name, o);
        end
    endtask

    task automatic check_under(input int got, input int exp_n, input string name);
        checks++;
        if (got != exp_n) begin
            errors++;
            $display("FAIL %s_underrun: pulses got %0d expected %0d", name, got, exp_n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge mclk);
        checks++;
        if ({s_ready, fifo_level, i2s_bclk, i2s_lrclk, i2s_data, underrun, s_ready4, level4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all 0",
                     {s_ready, fifo_level, i2s_bclk, i2s_lrclk, i2s_data, underrun, s_ready4, level4});
        end
        checks++;
        if (i2s_mclk !== mclk || i2s_mclk4 !== mclk) begin
            errors++;
            $display("FAIL mclk_passthru: got %b%b expected %b", i2s_mclk, i2s_mclk4, mclk);
        end
        rst_n = 1'b1;
        @(negedge mclk);
        checks++;
        if (s_ready !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: ready/level got %b/%0d expected 1/0", s_ready, fifo_level);
        end
    endtask

    task automatic test_lj;
        int nu;
        fmt_lj = 1'b1;
        push_frame(0, 64'h7FFE_8001, 1'b1, 1'b1);
        enable = 1'b1;
        check_bits(0, 64, "lj", nu);
        stop_and_check(0, "lj");
        check_under(nu, 0, "lj");
    endtask

    task automatic test_i2s;
        int nu;
        fmt_lj = 1'b0;
        push_frame(0, 64'h7FFE_8001, 1'b1, 1'b0);
        push_frame(0, 64'h1234_ABCD, 1'b1, 1'b0);
        enable = 1'b1;
        check_bits(0, 128, "i2s", nu);
        stop_and_check(0, "i2s");
        check_under(nu, 0, "i2s");
    endtask

    task automatic test_fifo_full;
        int nu;
        logic [63:0] f5;
        fmt_lj = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_frame(0, {32'h0, $urandom()}, 1'b1, 1'b1);
            checks++;
            if (fifo_level !== 3'(i)) begin
                errors++;
                $display("FAIL full_level%0d: got %0d expected %0d", i, fifo_level, i);
            end
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", s_ready);
        end
        f5 = {32'h0, $urandom()};
        s_data = f5[31:0];
        s_valid = 1'b1;
        enable = 1'b1;
        @(negedge mclk);
        checks++;
        if (fifo_level !== 3'd3 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_pop: level/ready got %0d/%b expected 3/1", fifo_level, s_ready);
        end
        @(negedge mclk);
        s_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL fifth_accept: level got %0d expected 4", fifo_level);
        end
        enqueue_frame(0, f5, prev0, 1'b1);
        prev0 = f5;
        check_bits(0, 320, "full", nu);
        stop_and_check(0, "full");
        check_under(nu, 0, "full");
    endtask

    task automatic test_abort;
        int nu;
        logic [63:0] f1, f2;
        f1 = 64'hA5A5_C3C3;
        f2 = 64'h0F0F_F00F;
        fmt_lj = 1'b1;
        push_frame(0, f1, 1'b0, 1'b1);
        push_frame(0, f2, 1'b0, 1'b1);
        enable = 1'b1;
        repeat (100) @(negedge mclk);
        stop_and_check(0, "abort");
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL abort_level: got %0d expected 1", fifo_level);
        end
        prev0 = f1;
        enqueue_frame(0, f2, prev0, 1'b1);
        prev0 = f2;
        enable = 1'b1;
        check_bits(0, 64, "restart", nu);
        stop_and_check(0, "restart");
        check_under(nu, 0, "restart");
    endtask

    task automatic test_underrun;
        int nu;
        logic [63:0] u;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        u = prev0;
`else
        u = '0;
`endif
        fmt_lj = 1'b1;
        enqueue_frame(0, u, prev0, 1'b1);
        enqueue_frame(0, u, u, 1'b1);
        prev0 = u;
        enable = 1'b1;
        check_bits(0, 128, "underrun", nu);
        stop_and_check(0, "underrun");
        check_under(nu, 2, "underrun");
    endtask

    task automatic test_reset_mid;
        int nu;
        fmt_lj = 1'b1;
        push_frame(0, 64'h5555_AAAA, 1'b0, 1'b1);
        push_frame(0, 64'h1111_2222, 1'b0, 1'b1);
        enable = 1'b1;
        repeat (60) @(negedge mclk);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if ({s_ready, fifo_level, i2s_bclk, i2s_lrclk, i2s_data, underrun} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected all 0",
                     {s_ready, fifo_level, i2s_bclk, i2s_lrclk, i2s_data, underrun});
        end
        @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        checks++;
        if (s_ready !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL midreset_release: ready/level got %b/%0d expected 1/0", s_ready, fifo_level);
        end
        prev0 = '0;
        enqueue_frame(0, 64'h0, prev0, 1'b1);
        enable = 1'b1;
        check_bits(0, 64, "postreset", nu);
        stop_and_check(0, "postreset");
        check_under(nu, 1, "postreset");
    endtask

    task automatic test_tdm4;
        int nu;
        fmt4 = 1'b1;
        push_frame(1, 64'h4444_3333_2222_1111, 1'b1, 1'b1);
        enable4 = 1'b1;
        check_bits(1, 64, "tdm_lj", nu);
        stop_and_check(1, "tdm_lj");
        check_under(nu, 0, "tdm_lj");
        fmt4 = 1'b0;
        push_frame(1, 64'h8001_7FFF_0F0F_C003, 1'b1, 1'b0);
        push_frame(1, 64'h0000_FFFF_1234_8000, 1'b1, 1'b0);
        enable4 = 1'b1;
        check_bits(1, 128, "tdm_i2s", nu);
        stop_and_check(1, "tdm_i2s");
        check_under(nu, 0, "tdm_i2s");
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; fmt_lj = 1'b0; s_valid = 1'b0; s_data = '0;
        enable4 = 1'b0; fmt4 = 1'b0; s_valid4 = 1'b0; s_data4 = '0;
        test_reset;
        test_lj;
        test_i2s;
        test_fifo_full;
        test_abort;
        test_underrun;
        test_reset_mid;
        test_tdm4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
